// File: rtl/mips_mem_pkg.sv
// Shared types and the store formatting function for the MEM-stage store path.
// mem_size_t : access size encoding taken from the EX/MEM register.
// st_req_t   : one formatted store (word-aligned address, lane data, byte enables).
// st_fmt_t   : formatter result, the store plus a misalignment flag.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_req_t;

  typedef struct packed {
    st_req_t req;
    logic    misalign;
  } st_fmt_t;

  // Narrow the register value, replicate it across lanes and pick the byte
  // enables for the addressed lane(s). Reserved sizes are reported as misaligned.
  function automatic st_fmt_t format_store(input logic [31:0] addr,
                                           input logic [31:0] data,
                                           input mem_size_t   size,
                                           input logic        big_endian);
    st_fmt_t    f;
    logic [1:0] o;
    logic [1:0] lane;
    o          = addr[1:0];
    lane       = big_endian ? (2'd3 - o) : o;
    f.req.addr  = {addr[31:2], 2'b00};
    f.req.wdata = data;
    f.req.be    = 4'b0000;
    f.misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        f.req.wdata = {4{data[7:0]}};
        f.req.be    = 4'b0001 << lane;
      end
      SZ_HALF: begin
        f.req.wdata = {2{data[15:0]}};
        f.misalign  = o[0];
        // The upper half-word lanes are selected by o[1] in little-endian
        // and by ~o[1] in big-endian.
        f.req.be    = (o[1] ^ big_endian) ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        f.req.be   = 4'b1111;
        f.misalign = (o != 2'b00);
      end
      default: begin
        f.misalign = 1'b1;
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/store_formatter_skid_buffer.sv
// Two-entry valid/ready buffer: an output register plus one skid entry.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data    upstream handshake; in_ready is the skid
//                                entry being empty, so it is purely registered
//   out_valid/out_ready/out_data downstream handshake; out_data holds steady
//                                while out_valid & ~out_ready
module skid_buffer
  import mips_mem_pkg::*;
#(
  parameter type T = st_req_t
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic out_vld_p1;
  T     out_p1;
  logic skid_vld_p1;
  T     skid_p1;
  logic push;

  assign in_ready  = ~skid_vld_p1;
  assign push      = in_valid & ~skid_vld_p1;
  assign out_valid = out_vld_p1;
  assign out_data  = out_p1;

  // Stage p1: output register and skid entry. A full skid implies a full
  // output register, and no push can happen while the skid is occupied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_p1  <= 1'b0;
      out_p1      <= '0;
      skid_vld_p1 <= 1'b0;
      skid_p1     <= '0;
    end else if (skid_vld_p1) begin
      if (out_ready) begin
        out_p1      <= skid_p1;
        skid_vld_p1 <= 1'b0;
      end
    end else if (!out_vld_p1 || out_ready) begin
      out_vld_p1 <= push;
      if (push) out_p1 <= in_data;
    end else if (push) begin
      skid_p1     <= in_data;
      skid_vld_p1 <= 1'b1;
    end
  end

endmodule

// File: rtl/store_formatter.sv
// MEM-stage store formatter: narrows a register value to byte/half/word,
// replicates it into the memory byte lanes, builds byte enables and a
// word-aligned address, and buffers the result behind a 2-entry skid buffer.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_addr, in_wdata, in_size   store request
//   mem_valid/mem_ready, mem_addr, mem_wdata, mem_be formatted store
//   misalign      one-cycle pulse after a misaligned/reserved request is dropped
//   misalign_cnt  saturating count of misalign pulses
module store_formatter
  import mips_mem_pkg::*;
#(
  parameter int BIG_ENDIAN = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_addr,
  input  logic [31:0]          in_wdata,
  input  logic [1:0]           in_size,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_be,
  output logic                 misalign,
  output logic [CNT_WIDTH-1:0] misalign_cnt
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  st_fmt_t fmt_p0;
  st_req_t mem_req;
  logic    drop_p0;

  assign fmt_p0  = format_store(in_addr, in_wdata, mem_size_t'(in_size), BIG_ENDIAN != 0);
  // Misaligned requests still handshake normally (so a full buffer stalls
  // them too) but never enter the buffer.
  assign drop_p0 = in_valid & in_ready & fmt_p0.misalign;

  skid_buffer #(.T(st_req_t)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid & ~fmt_p0.misalign),
    .in_ready  (in_ready),
    .in_data   (fmt_p0.req),
    .out_valid (mem_valid),
    .out_ready (mem_ready),
    .out_data  (mem_req)
  );

  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;
  assign mem_be    = mem_req.be;

  // Stage p1: misalignment pulse and its counter update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign     <= 1'b0;
      misalign_cnt <= '0;
    end else begin
      misalign <= drop_p0;
      if (drop_p0) misalign_cnt <= sat_inc(misalign_cnt);
    end
  end

endmodule

// File: tb/tb_store_formatter.sv
// Directed bench for store_formatter: little-endian, big-endian and a
// narrow-counter instance share one input stream.
module tb_store_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, mem_ready;
  logic [31:0] in_addr, in_wdata;
  logic [1:0]  in_size;

  logic        le_in_ready, le_mem_valid, le_misalign;
  logic [31:0] le_mem_addr, le_mem_wdata;
  logic [3:0]  le_mem_be;
  logic [15:0] le_cnt;

  logic        be_in_ready, be_mem_valid, be_misalign;
  logic [31:0] be_mem_addr, be_mem_wdata;
  logic [3:0]  be_mem_be;
  logic [15:0] be_cnt;

  logic        sat_in_ready, sat_mem_valid, sat_misalign;
  logic [31:0] sat_mem_addr, sat_mem_wdata;
  logic [3:0]  sat_mem_be;
  logic [1:0]  sat_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  store_formatter #(.BIG_ENDIAN(0), .CNT_WIDTH(16)) dut_le (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(le_in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size),
    .mem_valid(le_mem_valid), .mem_ready(mem_ready), .mem_addr(le_mem_addr),
    .mem_wdata(le_mem_wdata), .mem_be(le_mem_be), .misalign(le_misalign),
    .misalign_cnt(le_cnt)
  );

  store_formatter #(.BIG_ENDIAN(1), .CNT_WIDTH(16)) dut_be (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(be_in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size),
    .mem_valid(be_mem_valid), .mem_ready(mem_ready), .mem_addr(be_mem_addr),
    .mem_wdata(be_mem_wdata), .mem_be(be_mem_be), .misalign(be_misalign),
    .misalign_cnt(be_cnt)
  );

  store_formatter #(.BIG_ENDIAN(0), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size),
    .mem_valid(sat_mem_valid), .mem_ready(mem_ready), .mem_addr(sat_mem_addr),
    .mem_wdata(sat_mem_wdata), .mem_be(sat_mem_be), .misalign(sat_misalign),
    .misalign_cnt(sat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    in_valid = v;
    in_addr  = a;
    in_wdata = d;
    in_size  = s;
  endtask

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    tick();
    chk("rst_mem_valid", 32'(le_mem_valid), 32'h0);
    chk("rst_mem_addr",  le_mem_addr, 32'h0);
    chk("rst_mem_wdata", le_mem_wdata, 32'h0);
    chk("rst_mem_be",    32'(le_mem_be), 32'h0);
    chk("rst_misalign",  32'(le_misalign), 32'h0);
    chk("rst_cnt",       32'(le_cnt), 32'h0);
    reset = 1'b1;
    tick();
    chk("rst_in_ready",  32'(le_in_ready), 32'h1);

    // 1: little-endian byte at offset 3
    mem_ready = 1'b1;
    drive(1'b1, 32'h0000_1003, 32'h1234_56AB, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("t1_valid", 32'(le_mem_valid), 32'h1);
    chk("t1_addr",  le_mem_addr, 32'h0000_1000);
    chk("t1_wdata", le_mem_wdata, 32'hABAB_ABAB);
    chk("t1_be",    32'(le_mem_be), 32'h8);
    chk("t1_be_bigend", 32'(be_mem_be), 32'h1);
    tick();
    chk("t1_drained", 32'(le_mem_valid), 32'h0);

    // 2: half at offset 2, both endiannesses
    drive(1'b1, 32'h0000_2002, 32'h0000_BEEF, 2'b01);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("t2_be_valid", 32'(be_mem_valid), 32'h1);
    chk("t2_be_addr",  be_mem_addr, 32'h0000_2000);
    chk("t2_be_wdata", be_mem_wdata, 32'hBEEF_BEEF);
    chk("t2_be_be",    32'(be_mem_be), 32'h3);
    chk("t2_le_be",    32'(le_mem_be), 32'hC);
    chk("t2_be_mis",   32'(be_misalign), 32'h0);
    tick();

    // 3: misaligned word, misaligned half, reserved size, then one more half
    drive(1'b1, 32'h0000_3001, 32'hDEAD_BEEF, 2'b10);
    tick();
    chk("t3a_mis",   32'(le_misalign), 32'h1);
    chk("t3a_cnt",   32'(le_cnt), 32'h1);
    chk("t3a_valid", 32'(le_mem_valid), 32'h0);
    drive(1'b1, 32'h0000_3003, 32'hDEAD_BEEF, 2'b01);
    tick();
    chk("t3b_mis",   32'(le_misalign), 32'h1);
    chk("t3b_cnt",   32'(le_cnt), 32'h2);
    chk("t3b_valid", 32'(le_mem_valid), 32'h0);
    drive(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 2'b11);
    tick();
    chk("t3c_mis",   32'(le_misalign), 32'h1);
    chk("t3c_cnt",   32'(le_cnt), 32'h3);
    chk("t3c_valid", 32'(le_mem_valid), 32'h0);
    chk("t3c_in_ready", 32'(le_in_ready), 32'h1);
    drive(1'b1, 32'h0000_3001, 32'hDEAD_BEEF, 2'b01);
    tick();
    chk("t3d_cnt",     32'(le_cnt), 32'h4);
    chk("t3d_sat_cnt", 32'(sat_cnt), 32'h3);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    chk("t3e_mis",   32'(le_misalign), 32'h0);
    chk("t3e_cnt",   32'(le_cnt), 32'h4);
    chk("t3e_valid", 32'(le_mem_valid), 32'h0);

    // 4: backpressure, three words into a two-entry buffer
    mem_ready = 1'b0;
    drive(1'b1, 32'h0000_0010, 32'h0000_0010, 2'b10);
    tick();
    chk("t4a_valid", 32'(le_mem_valid), 32'h1);
    chk("t4a_addr",  le_mem_addr, 32'h10);
    chk("t4a_ready", 32'(le_in_ready), 32'h1);
    drive(1'b1, 32'h0000_0014, 32'h0000_0014, 2'b10);
    tick();
    chk("t4b_ready", 32'(le_in_ready), 32'h0);
    chk("t4b_addr",  le_mem_addr, 32'h10);
    drive(1'b1, 32'h0000_0018, 32'h0000_0018, 2'b10);
    tick();
    chk("t4c_ready", 32'(le_in_ready), 32'h0);
    chk("t4c_addr",  le_mem_addr, 32'h10);
    chk("t4c_wdata", le_mem_wdata, 32'h10);
    chk("t4c_be",    32'(le_mem_be), 32'hF);
    mem_ready = 1'b1;
    tick();
    chk("t4d_valid", 32'(le_mem_valid), 32'h1);
    chk("t4d_addr",  le_mem_addr, 32'h14);
    chk("t4d_ready", 32'(le_in_ready), 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("t4e_valid", 32'(le_mem_valid), 32'h1);
    chk("t4e_addr",  le_mem_addr, 32'h18);
    chk("t4e_wdata", le_mem_wdata, 32'h18);
    tick();
    chk("t4f_valid", 32'(le_mem_valid), 32'h0);

    // 5: back-to-back words with memory always ready
    for (int i = 0; i < 8; i++) begin
      chk("t5_ready", 32'(le_in_ready), 32'h1);
      drive(1'b1, 32'h0000_0100 + 32'(i) * 4, 32'h5500_0000 + 32'(i), 2'b10);
      tick();
      chk("t5_valid", 32'(le_mem_valid), 32'h1);
      chk("t5_addr",  le_mem_addr, 32'h0000_0100 + 32'(i) * 4);
      chk("t5_wdata", le_mem_wdata, 32'h5500_0000 + 32'(i));
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    chk("t5_drained", 32'(le_mem_valid), 32'h0);

    // 6: reset with two stores buffered
    mem_ready = 1'b0;
    drive(1'b1, 32'h0000_0200, 32'h1111_1111, 2'b10);
    tick();
    drive(1'b1, 32'h0000_0204, 32'h2222_2222, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("t6_full_valid", 32'(le_mem_valid), 32'h1);
    chk("t6_full_ready", 32'(le_in_ready), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(le_mem_valid), 32'h0);
    chk("t6_rst_addr",  le_mem_addr, 32'h0);
    chk("t6_rst_be",    32'(le_mem_be), 32'h0);
    chk("t6_rst_cnt",   32'(le_cnt), 32'h0);
    tick();
    reset     = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_replay", 32'(le_mem_valid), 32'h0);
    end
    chk("t6_ready", 32'(le_in_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
